// File: rtl/mbox_req_arb_if.sv
// MBOX request-side bundle: EBOX request, address, qualifiers and write data
// toward the MBOX, plus acceptance, retry, response and read data back.
interface mbox_req_arb_if #(
    parameter int VMAW  = 23,
    parameter int DATAW = 36
) ();
    logic             EBOX_REQ;
    logic [VMAW-1:0]  EBOX_VMA;
    logic             eboxRead;
    logic             eboxWrite;
    logic [DATAW-1:0] cacheDataWrite;
    logic             cshEBOXT0;
    logic             cshEBOXRetry;
    logic             mboxRespIn;
    logic [DATAW-1:0] cacheDataRead;

    modport master (
        output EBOX_REQ, EBOX_VMA, eboxRead, eboxWrite, cacheDataWrite,
        input  cshEBOXT0, cshEBOXRetry, mboxRespIn, cacheDataRead
    );

    modport slave (
        input  EBOX_REQ, EBOX_VMA, eboxRead, eboxWrite, cacheDataWrite,
        output cshEBOXT0, cshEBOXRetry, mboxRespIn, cacheDataRead
    );
endinterface

// File: rtl/mbox_req_arb.sv
// mbox_req_arb: round-robin arbiter for EBOX requester channels. Holds one
// request at a time, issues it to the MBOX, and handles retry with backoff,
// WAIT timeout and completion/error pulses back to the owning channel.
module mbox_req_arb #(
    parameter int NCHAN       = 2,
    parameter int VMAW        = 23,
    parameter int DATAW       = 36,
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_DELAY = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   CROBAR,
    input  logic [NCHAN-1:0]       chReq,
    input  logic [NCHAN-1:0]       chRead,
    input  logic [NCHAN-1:0]       chWrite,
    input  logic [NCHAN*VMAW-1:0]  chVMA,
    input  logic [NCHAN*DATAW-1:0] chWData,
    output logic [NCHAN-1:0]       chAck,
    output logic [NCHAN-1:0]       chDone,
    output logic [NCHAN-1:0]       chErr,
    output logic [DATAW-1:0]       rdata,
    mbox_req_arb_if.master         mbox
);
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int TW = $clog2(TIMEOUT);
    localparam int BW = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] BACKOFF = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    grant;
    logic [CW-1:0]    last_grant;
    logic [RW-1:0]    retry_cnt;
    logic [TW-1:0]    wait_cnt;
    logic [BW-1:0]    backoff_cnt;

    logic             pick_valid;
    logic [CW-1:0]    pick;
    int               idx;
    logic [VMAW-1:0]  sel_vma;
    logic [DATAW-1:0] sel_wdata;
    logic             sel_read;
    logic             sel_write;
    logic [RW-1:0]    retry_next;
    logic             retry_ok;
    logic [NCHAN-1:0] grant_hot;

    // Round-robin search: first requesting channel after last_grant, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = 0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            idx = int'(last_grant) + 1 + int'(i);
            if (idx >= NCHAN) idx = idx - NCHAN;
            if (!pick_valid && chReq[CW'(idx)]) begin
                pick_valid = 1'b1;
                pick       = CW'(idx);
            end
        end
    end

    // Select the picked channel's address, data and qualifiers.
    always_comb begin
        sel_vma   = '0;
        sel_wdata = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            if (pick == CW'(k)) begin
                sel_vma   = chVMA[k*VMAW +: VMAW];
                sel_wdata = chWData[k*DATAW +: DATAW];
                sel_read  = chRead[k];
                sel_write = chWrite[k];
            end
        end
    end

    // Retry accounting and one-hot owner mask.
    always_comb begin
        retry_next = retry_cnt + RW'(1);
        retry_ok   = (retry_next <= RW'(MAX_RETRY));
        grant_hot  = NCHAN'(1) << grant;
    end

    // Request FSM: capture, issue, wait for response, back off on retry.
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state               <= IDLE;
            grant               <= '0;
            last_grant          <= CW'(NCHAN - 1);
            retry_cnt           <= '0;
            wait_cnt            <= '0;
            backoff_cnt         <= '0;
            chAck               <= '0;
            chDone              <= '0;
            chErr               <= '0;
            rdata               <= '0;
            mbox.EBOX_REQ       <= 1'b0;
            mbox.EBOX_VMA       <= '0;
            mbox.eboxRead       <= 1'b0;
            mbox.eboxWrite      <= 1'b0;
            mbox.cacheDataWrite <= '0;
        end else begin
            chAck  <= '0;
            chDone <= '0;
            chErr  <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant               <= pick;
                        mbox.EBOX_VMA       <= sel_vma;
                        mbox.eboxRead       <= sel_read;
                        mbox.eboxWrite      <= sel_write;
                        mbox.cacheDataWrite <= sel_wdata;
                        retry_cnt           <= '0;
                        chAck               <= NCHAN'(1) << pick;
                        mbox.EBOX_REQ       <= 1'b1;
                        state               <= REQ;
                    end
                end
                REQ: begin
                    if (mbox.cshEBOXRetry) begin
                        retry_cnt     <= retry_next;
                        mbox.EBOX_REQ <= 1'b0;
                        if (retry_ok) begin
                            backoff_cnt <= '0;
                            state       <= BACKOFF;
                        end else begin
                            chErr      <= grant_hot;
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end else if (mbox.cshEBOXT0) begin
                        mbox.EBOX_REQ <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mbox.mboxRespIn) begin
                        if (mbox.eboxRead) rdata <= mbox.cacheDataRead;
                        chDone     <= grant_hot;
                        last_grant <= grant;
                        state      <= IDLE;
                    end else if (mbox.cshEBOXRetry) begin
                        retry_cnt <= retry_next;
                        if (retry_ok) begin
                            backoff_cnt <= '0;
                            state       <= BACKOFF;
                        end else begin
                            chErr      <= grant_hot;
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        chErr      <= grant_hot;
                        last_grant <= grant;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                BACKOFF: begin
                    if (backoff_cnt == BW'(RETRY_DELAY - 1)) begin
                        mbox.EBOX_REQ <= 1'b1;
                        state         <= REQ;
                    end else begin
                        backoff_cnt <= backoff_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mbox_req_arb.sv
// Testbench for mbox_req_arb: directed MBOX/channel stimulus, a transaction
// level reference model compared every cycle, plus literal spot checks.
module tb_mbox_req_arb;
    localparam int NCHAN = 2, VMAW = 23, DATAW = 36;
    localparam int MAX_RETRY = 3, RETRY_DELAY = 4, TIMEOUT = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   CROBAR;
    logic [NCHAN-1:0]       chReq, chRead, chWrite;
    logic [NCHAN*VMAW-1:0]  chVMA;
    logic [NCHAN*DATAW-1:0] chWData;
    logic [NCHAN-1:0]       chAck, chDone, chErr;
    logic [DATAW-1:0]       rdata;

    mbox_req_arb_if #(.VMAW(VMAW), .DATAW(DATAW)) mbox ();

    mbox_req_arb #(
        .NCHAN(NCHAN), .VMAW(VMAW), .DATAW(DATAW),
        .MAX_RETRY(MAX_RETRY), .RETRY_DELAY(RETRY_DELAY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .CROBAR(CROBAR),
        .chReq(chReq), .chRead(chRead), .chWrite(chWrite),
        .chVMA(chVMA), .chWData(chWData),
        .chAck(chAck), .chDone(chDone), .chErr(chErr),
        .rdata(rdata), .mbox(mbox)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit               m_on = 0;
    bit               m_busy, m_req, m_wait;
    int               m_boff, m_welap, m_tries, m_ch, m_last;
    logic [VMAW-1:0]  m_vma;
    logic             m_rd, m_wr;
    logic [DATAW-1:0] m_wd, m_rdata;
    logic [NCHAN-1:0] m_ack, m_done, m_err;

    task automatic model_finish(input bit err);
        if (err) m_err[m_ch] = 1'b1;
        else     m_done[m_ch] = 1'b1;
        m_busy = 0; m_req = 0; m_wait = 0;
        m_last = m_ch;
    endtask

    task automatic model_retry();
        m_tries++;
        m_req = 0; m_wait = 0;
        if (m_tries > MAX_RETRY) model_finish(1);
        else m_boff = RETRY_DELAY;
    endtask

    task automatic model_step();
        if (CROBAR) begin
            m_on = 1; m_busy = 0; m_req = 0; m_wait = 0;
            m_boff = 0; m_welap = 0; m_tries = 0; m_ch = 0; m_last = NCHAN - 1;
            m_vma = '0; m_rd = 0; m_wr = 0; m_wd = '0; m_rdata = '0;
            m_ack = '0; m_done = '0; m_err = '0;
            return;
        end
        if (!m_on) return;
        m_ack = '0; m_done = '0; m_err = '0;
        if (!m_busy) begin
            for (int i = 0; i < NCHAN; i++) begin
                int c;
                c = (m_last + 1 + i) % NCHAN;
                if (!m_busy && chReq[c]) begin
                    m_busy = 1; m_req = 1; m_wait = 0; m_tries = 0; m_ch = c;
                    m_vma = chVMA[c*VMAW +: VMAW];
                    m_wd  = chWData[c*DATAW +: DATAW];
                    m_rd  = chRead[c];
                    m_wr  = chWrite[c];
                    m_ack[c] = 1'b1;
                end
            end
        end else if (m_req) begin
            if (mbox.cshEBOXRetry) model_retry();
            else if (mbox.cshEBOXT0) begin m_req = 0; m_wait = 1; m_welap = 0; end
        end else if (m_wait) begin
            if (mbox.mboxRespIn) begin
                if (m_rd) m_rdata = mbox.cacheDataRead;
                model_finish(0);
            end else if (mbox.cshEBOXRetry) model_retry();
            else begin
                m_welap++;
                if (m_welap == TIMEOUT) model_finish(1);
            end
        end else begin
            m_boff--;
            if (m_boff == 0) m_req = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        if (m_on) begin
            check("chAck", chAck, m_ack);
            check("chDone", chDone, m_done);
            check("chErr", chErr, m_err);
            check("rdata", rdata, m_rdata);
            check("EBOX_REQ", mbox.EBOX_REQ, m_req);
            check("EBOX_VMA", mbox.EBOX_VMA, m_vma);
            check("eboxRead", mbox.eboxRead, m_rd);
            check("eboxWrite", mbox.eboxWrite, m_wr);
            check("cacheDataWrite", mbox.cacheDataWrite, m_wd);
            check("pulse_exclusive", ($countones({chAck, chDone, chErr}) <= 1), 1'b1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (mbox.EBOX_REQ !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (mbox.EBOX_REQ !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s: EBOX_REQ never rose within 20 cycles", name);
        end
    endtask

    task automatic serve(input int gap, input bit retry_with_resp, output logic [NCHAN-1:0] done_seen);
        wait_req("serve_req");
        mbox.cshEBOXT0 = 1'b1;
        @(negedge clk);
        mbox.cshEBOXT0 = 1'b0;
        repeat (gap) @(negedge clk);
        mbox.mboxRespIn   = 1'b1;
        mbox.cshEBOXRetry = retry_with_resp;
        @(negedge clk);
        mbox.mboxRespIn   = 1'b0;
        mbox.cshEBOXRetry = 1'b0;
        done_seen = chDone;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCHAN-1:0] d;
        logic [NCHAN-1:0] fair_exp [4];
        int lows, highs, k;
        fair_exp[0] = 2'b01; fair_exp[1] = 2'b10; fair_exp[2] = 2'b01; fair_exp[3] = 2'b10;

        CROBAR = 1'b1; chReq = '0; chRead = '0; chWrite = '0; chVMA = '0; chWData = '0;
        mbox.cshEBOXT0 = 1'b0; mbox.cshEBOXRetry = 1'b0; mbox.mboxRespIn = 1'b0;
        mbox.cacheDataRead = '0;
        repeat (3) @(negedge clk);
        check("rst_req", mbox.EBOX_REQ, 1'b0);
        check("rst_vma", mbox.EBOX_VMA, '0);
        check("rst_rdata", rdata, '0);
        check("rst_pulses", {chAck, chDone, chErr}, '0);

        // Single read on channel 0.
        CROBAR = 1'b0;
        chVMA[0 +: VMAW] = 23'h12345; chRead = 2'b01; chWrite = 2'b00; chReq = 2'b01;
        @(negedge clk);
        check("read_ack0", chAck, 2'b01);
        check("read_req_rise", mbox.EBOX_REQ, 1'b1);
        check("read_vma", mbox.EBOX_VMA, 23'h12345);
        chReq = 2'b00;
        @(negedge clk);
        mbox.cshEBOXT0 = 1'b1;
        @(negedge clk);
        mbox.cshEBOXT0 = 1'b0;
        check("read_req_drop", mbox.EBOX_REQ, 1'b0);
        @(negedge clk);
        mbox.mboxRespIn = 1'b1; mbox.cacheDataRead = 36'o123456701234;
        @(negedge clk);
        mbox.mboxRespIn = 1'b0;
        check("read_done0", chDone, 2'b01);
        check("read_rdata", rdata, 36'o123456701234);
        @(negedge clk);
        check("read_done_once", chDone, 2'b00);

        // Fairness after reset; ch0 has both qualifiers, ch1 neither.
        CROBAR = 1'b1;
        @(negedge clk);
        CROBAR = 1'b0;
        check("rst2_rdata", rdata, '0);
        chVMA[0 +: VMAW] = 23'h00AAA; chVMA[VMAW +: VMAW] = 23'h55555;
        chWData[0 +: DATAW] = 36'h111111111; chWData[DATAW +: DATAW] = 36'h222222222;
        chRead = 2'b01; chWrite = 2'b01; mbox.cacheDataRead = 36'o765432107654;
        chReq = 2'b11;
        for (int n = 0; n < 4; n++) begin
            serve(1, 1'b0, d);
            if (n == 3) chReq = 2'b00;
            check("fair_grant", d, fair_exp[n]);
        end

        // Retry in WAIT on channel 1 write: 4 backoff cycles then re-issue.
        chVMA[VMAW +: VMAW] = 23'h7ABCD; chWData[DATAW +: DATAW] = 36'h987654321;
        chRead = 2'b00; chWrite = 2'b10; chReq = 2'b10;
        wait_req("retry_req");
        check("retry_ack1", chAck, 2'b10);
        chReq = 2'b00;
        mbox.cshEBOXT0 = 1'b1;
        @(negedge clk);
        mbox.cshEBOXT0 = 1'b0;
        @(negedge clk);
        mbox.cshEBOXRetry = 1'b1;
        @(negedge clk);
        mbox.cshEBOXRetry = 1'b0;
        lows = 0;
        while (mbox.EBOX_REQ == 1'b0 && lows < 20) begin lows++; @(negedge clk); end
        check("backoff_len", lows, 4);
        check("reissue_vma", mbox.EBOX_VMA, 23'h7ABCD);
        check("reissue_write", mbox.eboxWrite, 1'b1);
        serve(0, 1'b0, d);
        check("retry_done1", d, 2'b10);

        // Retry exhaustion on channel 0; first retry collides with T0 in REQ.
        chVMA[0 +: VMAW] = 23'h00F0F; chRead = 2'b01; chWrite = 2'b00; chReq = 2'b01;
        for (int r = 0; r < 4; r++) begin
            wait_req("exhaust_req");
            chReq = 2'b00;
            mbox.cshEBOXRetry = 1'b1;
            mbox.cshEBOXT0 = (r == 0);
            @(negedge clk);
            mbox.cshEBOXRetry = 1'b0;
            mbox.cshEBOXT0 = 1'b0;
        end
        check("exhaust_err0", chErr, 2'b01);
        check("exhaust_no_done", chDone, 2'b00);
        highs = 0;
        repeat (8) begin @(negedge clk); if (mbox.EBOX_REQ) highs++; end
        check("exhaust_idle", highs, 0);

        // Response wins over simultaneous retry in WAIT.
        chRead = 2'b10; chWrite = 2'b00; chReq = 2'b10;
        mbox.cacheDataRead = 36'o777000111222;
        wait_req("collide_req");
        chReq = 2'b00;
        serve(2, 1'b1, d);
        check("collide_done1", d, 2'b10);
        check("collide_no_err", chErr, 2'b00);
        check("collide_rdata", rdata, 36'o777000111222);

        // WAIT timeout on channel 0.
        chRead = 2'b00; chWrite = 2'b01; chReq = 2'b01;
        wait_req("timeout_req");
        chReq = 2'b00;
        mbox.cshEBOXT0 = 1'b1;
        @(negedge clk);
        mbox.cshEBOXT0 = 1'b0;
        k = 0;
        while (chErr[0] !== 1'b1 && k < 400) begin k++; @(negedge clk); end
        check("timeout_cycles", k, 255);

        // Reset mid-WAIT abandons the request.
        chVMA[VMAW +: VMAW] = 23'h3C3C3; chRead = 2'b10; chWrite = 2'b00; chReq = 2'b10;
        wait_req("crobar_req");
        chReq = 2'b00;
        mbox.cshEBOXT0 = 1'b1;
        @(negedge clk);
        mbox.cshEBOXT0 = 1'b0;
        @(negedge clk);
        CROBAR = 1'b1; mbox.mboxRespIn = 1'b1;
        @(negedge clk);
        CROBAR = 1'b0; mbox.mboxRespIn = 1'b0;
        check("crobar_req", mbox.EBOX_REQ, 1'b0);
        check("crobar_vma", mbox.EBOX_VMA, '0);
        check("crobar_qual", {mbox.eboxRead, mbox.eboxWrite}, 2'b00);
        check("crobar_wdata", mbox.cacheDataWrite, '0);
        check("crobar_rdata", rdata, '0);
        check("crobar_pulses", {chAck, chDone, chErr}, '0);
        @(negedge clk);
        check("crobar_no_late", {chDone, chErr}, '0);
        chReq = 2'b11;
        wait_req("post_rst_req");
        check("post_rst_grant0", chAck, 2'b01);
        chReq = 2'b00;
        serve(0, 1'b0, d);
        check("post_rst_done0", d, 2'b01);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mbox_req_arb.md
MBOX_REQ_ARB -- requirements
Module: mbox_req_arb

Interface
REQ-001 Parameter NCHAN, default 2, meaning number of EBOX requester channels (1..8).
REQ-002 Parameter VMAW, default 23, meaning VMA width (EBOX_VMA[13:35]).
REQ-003 Parameter DATAW, default 36, meaning data word width.
REQ-004 Parameter MAX_RETRY, default 3, meaning retries allowed before error.
REQ-005 Parameter RETRY_DELAY, default 4, meaning backoff cycles before re-issue (>=1).
REQ-006 Parameter TIMEOUT, default 255, meaning WAIT cycles before error (>=2).
REQ-007 Port clk  in  1  the single clock; all logic on its rising edge.
REQ-008 Port CROBAR  in  1  reset, synchronous and active-high.
REQ-009 Ports chReq/chRead/chWrite  in  NCHAN each  per-channel request, read and write qualifiers.
REQ-010 Ports chVMA  in  NCHAN*VMAW and chWData  in  NCHAN*DATAW  per-channel address and write data; channel k at slice k.
REQ-011 Ports chAck/chDone/chErr  out  NCHAN each  one-cycle capture, completion and error pulses.
REQ-012 Port rdata  out  DATAW  read data, valid in the chDone cycle.
REQ-013 Ports EBOX_REQ  out  1, EBOX_VMA  out  VMAW, eboxRead  out  1, eboxWrite  out  1, cacheDataWrite  out  DATAW  MBOX request side.
REQ-014 Ports cshEBOXT0, cshEBOXRetry, mboxRespIn  in  1 each, and cacheDataRead  in  DATAW  MBOX acceptance, retry, response and read data.

Function
REQ-015 The block SHALL implement states IDLE, REQ, WAIT and BACKOFF, and hold at most one request.
REQ-016 In IDLE with any chReq high, the block SHALL grant round-robin starting at channel lastGrant+1 (mod NCHAN), then latch VMA, read, write, data and channel index, and go to REQ.
REQ-017 chAck[g] SHALL pulse, and EBOX_REQ SHALL rise, in the cycle after the capture edge; chReq seen outside IDLE SHALL be ignored.
REQ-018 A channel asserting both or neither of chRead/chWrite SHALL still be granted; the latched qualifiers SHALL drive eboxRead/eboxWrite unchanged.
REQ-019 In REQ, EBOX_REQ SHALL stay high with EBOX_VMA, eboxRead, eboxWrite and cacheDataWrite stable until cshEBOXT0 or cshEBOXRetry.
REQ-020 In REQ, cshEBOXT0 SHALL transition to WAIT and drop EBOX_REQ on the next cycle; cshEBOXRetry SHALL win over a simultaneous cshEBOXT0.
REQ-021 In WAIT, mboxRespIn SHALL register cacheDataRead into rdata (reads only; rdata otherwise holds), pulse chDone[g] the next cycle, update lastGrant to g, and return to IDLE.
REQ-022 In WAIT, mboxRespIn SHALL win over a simultaneous cshEBOXRetry.
REQ-023 In REQ or WAIT, cshEBOXRetry SHALL increment retryCnt; with the new value <= MAX_RETRY the block SHALL enter BACKOFF, otherwise pulse chErr[g] and return to IDLE.
REQ-024 BACKOFF SHALL last exactly RETRY_DELAY cycles with EBOX_REQ low, then re-enter REQ with the original latched request.
REQ-025 A WAIT cycle counter SHALL clear on WAIT entry; reaching TIMEOUT without mboxRespIn SHALL pulse chErr[g] and return to IDLE.
REQ-026 chDone and chErr SHALL never both be high; at most one bit of chAck|chDone|chErr SHALL be high in any cycle.
REQ-027 retryCnt SHALL clear on every capture.
REQ-028 lastGrant SHALL update on chErr as on chDone.

Reset
REQ-029 With CROBAR high at a clock edge, the block SHALL enter IDLE regardless of state, abandoning any in-flight request without chDone or chErr.
REQ-030 Reset values SHALL be: EBOX_REQ=0, eboxRead=0, eboxWrite=0, EBOX_VMA=0, cacheDataWrite=0, rdata=0, chAck=chDone=chErr=0, retryCnt=0, timeout counter=0, lastGrant=NCHAN-1.

Verification
REQ-031 Single read: ch0 chReq, chRead=1, VMA=0x12345; T0 two cycles later; mboxRespIn with cacheDataRead=0o123456701234 -> chAck[0] then EBOX_REQ, rdata=0o123456701234, chDone[0] once.
REQ-032 Fairness: ch0 and ch1 requesting continuously after reset -> grants alternate 0,1,0,1 over four completions.
REQ-033 Retry: cshEBOXRetry once in WAIT -> EBOX_REQ low exactly 4 cycles, then the same VMA is re-issued, then chDone.
REQ-034 Retry exhaustion: four cshEBOXRetry pulses -> chErr[g] after the fourth retry, no chDone, return to IDLE.
REQ-035 Collisions and reset: T0 with retry in REQ -> BACKOFF; response with retry in WAIT -> chDone; no response for 255 WAIT cycles -> chErr; CROBAR mid-WAIT -> all outputs at reset values the next cycle.
